multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Op, input, 7, opcode field of the instruction register.
REQ-004 SHALL have port MemReady, input, 1, memory access complete this cycle.
REQ-005 SHALL have outputs IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource, MemToReg, RegWrite, IllegalOp, each 1 bit, datapath enables/selects.
REQ-006 SHALL have outputs ALUSrcA (2: 00 PC, 01 OldPC, 10 regA), ALUSrcB (2: 00 regB, 01 const 4, 10 imm) and ALUOp (2: 00 add, 01 sub, 10 R-funct, 11 I-funct).
REQ-007 SHALL have output State, 4 bits, current FSM state encoding, for debug.

Function
REQ-008 SHALL implement a Moore FSM with a registered 4-bit state; outputs are decoded from state only, except IRWrite, PCWrite and IllegalOp (see below). Every output not listed for a state is 0.
REQ-009 SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-010 FETCH: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00; IRWrite=PCWrite=MemReady; holds while MemReady=0, else to DECODE.
REQ-011 DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (branch target into ALUOut); next by Op: 0000011 or 0100011 -> MEMADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, other -> FETCH.
REQ-012 IllegalOp SHALL be 1 in DECODE exactly when Op is not one of the five supported opcodes: a one-cycle pulse.
REQ-013 MEMADR: ALUSrcA=10, ALUSrcB=10, ALUOp=00; to MEMREAD if Op=0000011, else MEMWRITE.
REQ-014 MEMREAD: IorD=1, MemRead=1; hold until MemReady=1, then MEMWB.
REQ-015 MEMWB: RegWrite=1, MemToReg=1; to FETCH.
REQ-016 MEMWRITE: IorD=1, MemWrite=1; hold until MemReady=1, then FETCH.
REQ-017 EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUOp=11; both to ALUWB.
REQ-018 ALUWB: RegWrite=1, MemToReg=0; to FETCH.
REQ-019 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1; to FETCH. The datapath ANDs PCWriteCond with ALU Zero.
REQ-020 Zero-wait latency (MemReady=1 in every cycle): BEQ 3, R/ORI/SB 4, LB 5 cycles, FETCH to FETCH.
REQ-021 Op SHALL be sampled only in DECODE and MEMADR. Op changes in other states have no effect.
REQ-022 MemReady outside FETCH/MEMREAD/MEMWRITE SHALL be ignored. A MemReady stuck at 0 holds the state indefinitely, with outputs stable.

Reset
REQ-023 Reset assertion SHALL force State=FETCH immediately, independent of clk.
REQ-024 While reset=1, all 1-bit outputs and ALUSrcA/ALUSrcB/ALUOp SHALL be 0. This includes MemWrite: an in-flight store is aborted the same cycle.
REQ-025 The first rising edge after reset release SHALL occur in FETCH with MemRead=1.
REQ-026 Reset mid-operation (any state) SHALL discard the instruction; no RegWrite or PCWrite is emitted for it.

Structure
REQ-027 The shared package riscv_ctrl_pkg SHALL hold the opcode constants, state codes, and the ALUOp/ALUSrcA/ALUSrcB encodings. The existing single-cycle decoder shall reuse the opcode constants.
REQ-028 The output decode SHALL be a sub-module ctrl_output_decode (State, MemReady, Op in; control outputs out). Next-state and state register stay in multicycle_control.
REQ-029 Target size: 120-400 lines of RTL. No datapath registers inside this block.

Verification
REQ-030 Reset, then Op=0110011, MemReady=1 -> State 0,1,6,8,0; RegWrite=1 only in state 8; ALUOp=10 in state 6.
REQ-031 Op=0000011, MemReady=0 for 3 cycles in MEMREAD -> State holds at 3 for 3 cycles, MemRead=1 and IorD=1 throughout; then 4 (RegWrite=1, MemToReg=1), then 0.
REQ-032 Op=1100011 -> State 0,1,9,0; PCWriteCond=1, PCSource=1, ALUOp=01 in state 9; RegWrite never 1.
REQ-033 Op=1111111 -> IllegalOp=1 for exactly the DECODE cycle, then FETCH; no RegWrite/MemWrite.
REQ-034 Op=0100011, reset asserted mid-cycle in MEMWRITE -> MemWrite falls to 0 asynchronously, State=0, all outputs 0 until release.
REQ-035 Fetch with MemReady=0 for 2 cycles -> IRWrite=PCWrite=0 in those cycles, both 1 in the MemReady=1 cycle only.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RISC-V multicycle and single-cycle controllers:
// opcodes, FSM state codes, ALU select encodings and the control bundle.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_REGA  = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_REGB = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
        alu_src_a_t alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode for the multicycle controller; only the fetch strobes and
// the illegal-opcode flag look at anything besides the state.
module ctrl_output_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t      State,
    input  logic        MemReady,
    input  logic [6:0]  Op,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (State)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                // Instruction and PC+4 are only committed on the cycle the read returns
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !op_supported(Op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_REGA;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_REGA;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALU_RFUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_REGA;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_IFUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                // Datapath qualifies pc_write_cond with ALU Zero
                ctrl.alu_src_a     = SRCA_REGA;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: state register and next-state logic here,
// output decode in ctrl_output_decode, everything forced low while in reset.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] State
);

    state_t state;
    ctrl_t  ctrl;
    ctrl_t  ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXEC_R;
                        OP_ITYPE:          state <= S_EXEC_I;
                        OP_BRANCH:         state <= S_BRANCH;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (MemReady) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (MemReady) state <= S_FETCH;
                S_EXEC_R,
                S_EXEC_I:   state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    ctrl_output_decode u_decode (
        .State    (state),
        .MemReady (MemReady),
        .Op       (Op),
        .ctrl     (ctrl)
    );

    // Reset gates the decode so an in-flight store drops MemWrite without a clock
    assign ctrl_q = reset ? '0 : ctrl;

    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign PCSource    = ctrl_q.pc_source;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    assign IllegalOp   = ctrl_q.illegal_op;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model feeding a
// per-cycle expectation queue, popped and compared by an independent monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Op;
    logic       MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic       PCSource, MemToReg, RegWrite, IllegalOp;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State)
    );

    function automatic logic [19:0] got_vec();
        return {State, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                PCSource, MemToReg, RegWrite, IllegalOp, ALUSrcA, ALUSrcB, ALUOp};
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011;
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic logic [19:0] expv(input int st, input bit mr, input logic [6:0] op);
        logic iord, mrd, mw, irw, pcw, pcc, pcs, m2r, rw, ill;
        logic [1:0] sa, sb, aop;
        {iord, mrd, mw, irw, pcw, pcc, pcs, m2r, rw, ill} = '0;
        {sa, sb, aop} = '0;
        case (st)
            0: begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1: begin sa = 2'b01; sb = 2'b10; ill = !legal(op); end
            2: begin sa = 2'b10; sb = 2'b10; end
            3: begin iord = 1; mrd = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin iord = 1; mw = 1; end
            6: begin sa = 2'b10; aop = 2'b10; end
            7: begin sa = 2'b10; sb = 2'b10; aop = 2'b11; end
            8: begin rw = 1; end
            9: begin sa = 2'b10; aop = 2'b01; pcc = 1; pcs = 1; end
            default: ;
        endcase
        return {4'(st), iord, mrd, mw, irw, pcw, pcc, pcs, m2r, rw, ill, sa, sb, aop};
    endfunction

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and queue what the DUT should show
    task automatic step(input int st, input bit mr, input logic [6:0] op);
        @(posedge clk);
        #1;
        MemReady = mr;
        Op       = op;
        exp_q.push_back(expv(st, mr, op));
    endtask

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    // Instruction-level model: the sequence of states one instruction walks through.
    // Op is only meaningful in DECODE/MEMADR and MemReady only in memory waits, so both are randomised elsewhere.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step(0, 1'b0, junk());
        step(0, 1'b1, junk());
        step(1, 1'($urandom), op);
        case (op)
            7'b0000011: begin
                step(2, 1'($urandom), op);
                for (int i = 0; i < mw; i++) step(3, 1'b0, junk());
                step(3, 1'b1, junk());
                step(4, 1'($urandom), junk());
            end
            7'b0100011: begin
                step(2, 1'($urandom), op);
                for (int i = 0; i < mw; i++) step(5, 1'b0, junk());
                step(5, 1'b1, junk());
            end
            7'b0110011: begin step(6, 1'($urandom), junk()); step(8, 1'($urandom), junk()); end
            7'b0010011: begin step(7, 1'($urandom), junk()); step(8, 1'($urandom), junk()); end
            7'b1100011: step(9, 1'($urandom), junk());
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            e = exp_q.pop_front();
            cyc_n++;
            checks++;
            if (got_vec() !== e) begin
                errors++;
                $display("FAIL cycle %0d: got %h expected %h", cyc_n, got_vec(), e);
            end
        end
    end

    initial begin
        logic [6:0] ops[5];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011;

        reset = 1'b1; Op = '0; MemReady = 1'b1;
        #1 chk("reset_outputs", got_vec(), 20'h0);
        @(posedge clk); #1 chk("reset_held_over_edge", got_vec(), 20'h0);
        @(negedge clk);
        reset = 1'b0; MemReady = 1'b0;
        #1 chk("release_fetch", got_vec(), expv(0, 1'b0, Op));

        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 3);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b1111111, 0, 0);
        run_instr(7'b0100011, 2, 0);
        run_instr(7'b0010011, 0, 0);
        run_instr(7'b0000011, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            int sel;
            sel = $urandom_range(0, 5);
            op  = (sel == 5) ? junk() : ops[sel];
            run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        end
        @(negedge clk);
        #1 chk("queue_drained", 20'(exp_q.size()), 20'h0);

        // Store stalled in MEMWRITE, then reset lands mid-cycle
        @(posedge clk); #1 Op = 7'b0100011; MemReady = 1'b1;
        @(posedge clk); #1 MemReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 chk("store_in_memwrite", got_vec(), expv(5, 1'b0, Op));
        #2 reset = 1'b1;
        #1 chk("async_reset_abort", got_vec(), 20'h0);
        @(posedge clk); #1 chk("reset_hold", got_vec(), 20'h0);
        @(negedge clk);
        reset = 1'b0; MemReady = 1'b0;
        #1 chk("rerelease_fetch", got_vec(), expv(0, 1'b0, Op));
        @(posedge clk); #1 chk("fetch_stall_after_reset", got_vec(), expv(0, 1'b0, Op));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
